// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the key event encoder
package synth_pkg;

  localparam int N_KEYS_DEFAULT = 8;
  localparam int KEY_W_DEFAULT  = $clog2(N_KEYS_DEFAULT);

  typedef struct packed {
    logic [KEY_W_DEFAULT-1:0] key;
    logic                     press;
  } key_evt_t;

  typedef enum logic {
    KE_IDLE,
    KE_OFFER
  } key_enc_state_t;

endpackage

// File: rtl/rr_first_set.sv
// rtl/rr_first_set.sv - round-robin first-set search, starting just after ptr
module rr_first_set #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Offsets run 1..N so the previous winner (ptr) is examined last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - turns debounced key level changes into press/release events
// Served round-robin over a valid/ready handshake; net-zero changes are coalesced away.
module key_event_encoder
  import synth_pkg::*;
#(
  parameter  int N_KEYS = N_KEYS_DEFAULT,
  localparam int KEY_W  = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KEY_W-1:0]  evt_key,
  output logic              evt_press,
  output logic [KEY_W:0]    keys_down
);

  key_enc_state_t    state_q;
  logic [N_KEYS-1:0] key_q;
  logic [N_KEYS-1:0] reported_q, reported_d;
  logic [KEY_W-1:0]  rr_ptr_q;
  logic              evt_valid_q;
  logic [KEY_W-1:0]  evt_key_q;
  logic              evt_press_q;
  logic [KEY_W:0]    keys_down_q, keys_down_d;

  logic [N_KEYS-1:0] pending;
  logic              sel_found;
  logic [KEY_W-1:0]  sel_idx;
  logic              accept;

  assign pending = key_q ^ reported_q;
  assign accept  = (state_q == KE_OFFER) && evt_valid_q && evt_ready;

  rr_first_set #(.N(N_KEYS)) u_rr (
    .req   (pending),
    .ptr   (rr_ptr_q),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // keys_down tracks reported exactly, so it cannot leave 0..N_KEYS.
  always_comb begin
    reported_d  = reported_q;
    keys_down_d = keys_down_q;
    if (accept) begin
      reported_d[evt_key_q] = evt_press_q;
      keys_down_d = evt_press_q ? keys_down_q + (KEY_W+1)'(1)
                                : keys_down_q - (KEY_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= KE_IDLE;
      key_q       <= '0;
      reported_q  <= '0;
      rr_ptr_q    <= KEY_W'(N_KEYS - 1);
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_press_q <= 1'b0;
      keys_down_q <= '0;
    end else begin
      key_q       <= key_level;
      reported_q  <= reported_d;
      keys_down_q <= keys_down_d;
      case (state_q)
        KE_IDLE: begin
          if (sel_found) begin
            evt_key_q   <= sel_idx;
            evt_press_q <= key_q[sel_idx];
            rr_ptr_q    <= sel_idx;
            evt_valid_q <= 1'b1;
            state_q     <= KE_OFFER;
          end
        end
        KE_OFFER: begin
          // Offered event is frozen until accepted, whatever key_q does meanwhile.
          if (accept) begin
            evt_valid_q <= 1'b0;
            state_q     <= KE_IDLE;
          end
        end
        default: state_q <= KE_IDLE;
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_press = evt_press_q;
  assign keys_down = keys_down_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - directed self-checking bench for key_event_encoder
module tb_key_event_encoder;
  import synth_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] key_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;
  logic [3:0] keys_down;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  key_evt_t exp_evt;
  key_evt_t got_evt;

  key_event_encoder #(.N_KEYS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_level (key_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_press (evt_press),
    .keys_down (keys_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign got_evt = '{key: evt_key, press: evt_press};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] lvl, input logic rdy);
    rst       = 1'b0;
    key_level = lvl;
    evt_ready = rdy;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    key_level = 8'hFF;
    evt_ready = 1'b1;
    repeat (3) tick();
    vec_cnt++;
    if ({evt_valid, evt_key, evt_press, keys_down} !== 9'b0) begin
      miss_cnt++;
      $display("FAIL reset_outputs: got v=%0b k=%0d p=%0b d=%0d, expected all 0",
               evt_valid, evt_key, evt_press, keys_down);
    end
    vec_cnt++;
    if (dut.rr_ptr_q !== 3'd7) begin
      miss_cnt++;
      $display("FAIL reset_rr_ptr: got %0d expected 7", dut.rr_ptr_q);
    end
  endtask

  task automatic test_first_press();
    apply_reset(8'b0000_0001, 1'b1);
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL t1_valid_edge1: got %0b expected 0", evt_valid);
    end
    tick();
    exp_evt = '{key: 3'd0, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t1_event_edge2: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd1) begin
      miss_cnt++;
      $display("FAIL t1_accept: got v=%0b down=%0d expected v=0 down=1", evt_valid, keys_down);
    end
  endtask

  task automatic test_hold_offer();
    apply_reset(8'h00, 1'b0);
    tick();
    key_level = 8'h10;
    tick();
    tick();
    exp_evt = '{key: 3'd4, press: 1'b1};
    for (int i = 0; i < 6; i++) begin
      vec_cnt++;
      if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
        miss_cnt++;
        $display("FAIL t2_stable_cycle%0d: got v=%0b evt=%0h expected v=1 evt=%0h", i, evt_valid, got_evt, exp_evt);
      end
      if (i < 5) tick();
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd1) begin
      miss_cnt++;
      $display("FAIL t2_accept: got v=%0b down=%0d expected v=0 down=1", evt_valid, keys_down);
    end
    evt_ready = 1'b1;
    repeat (4) tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd1) begin
      miss_cnt++;
      $display("FAIL t2_single_accept: got v=%0b down=%0d expected v=0 down=1", evt_valid, keys_down);
    end
  endtask

  task automatic test_round_robin();
    apply_reset(8'h00, 1'b1);
    tick();
    key_level = 8'h24;
    tick();
    tick();
    exp_evt = '{key: 3'd2, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t3_first_key2: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL t3_idle_gap: got v=%0b expected 0", evt_valid);
    end
    tick();
    exp_evt = '{key: 3'd5, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t3_second_key5: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    repeat (5) tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd2 || dut.rr_ptr_q !== 3'd5) begin
      miss_cnt++;
      $display("FAIL t3_drained: got v=%0b down=%0d ptr=%0d expected v=0 down=2 ptr=5",
               evt_valid, keys_down, dut.rr_ptr_q);
    end
  endtask

  task automatic test_coalesce();
    apply_reset(8'h00, 1'b0);
    tick();
    key_level = 8'h02;
    tick();
    tick();
    key_level = 8'h0A;
    repeat (3) tick();
    key_level = 8'h02;
    repeat (2) tick();
    exp_evt = '{key: 3'd1, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t4_blocked_key1: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    evt_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (evt_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL t4_no_key3_cycle%0d: got v=%0b key=%0d expected v=0", i, evt_valid, evt_key);
      end
      tick();
    end
    vec_cnt++;
    if (keys_down !== 4'd1) begin
      miss_cnt++; $display("FAIL t4_keys_down: got %0d expected 1", keys_down);
    end
  endtask

  task automatic test_reversal();
    apply_reset(8'h00, 1'b0);
    tick();
    key_level = 8'h40;
    tick();
    tick();
    key_level = 8'h00;
    tick();
    tick();
    exp_evt = '{key: 3'd6, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t5_press_held: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    evt_ready = 1'b1;
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd1) begin
      miss_cnt++;
      $display("FAIL t5_press_accept: got v=%0b down=%0d expected v=0 down=1", evt_valid, keys_down);
    end
    tick();
    exp_evt = '{key: 3'd6, press: 1'b0};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t5_release_evt: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd0) begin
      miss_cnt++;
      $display("FAIL t5_release_accept: got v=%0b down=%0d expected v=0 down=0", evt_valid, keys_down);
    end
  endtask

  task automatic test_reset_mid_offer();
    apply_reset(8'h00, 1'b1);
    tick();
    key_level = 8'h01;
    repeat (3) tick();
    evt_ready = 1'b0;
    key_level = 8'h09;
    tick();
    tick();
    exp_evt = '{key: 3'd3, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt || keys_down !== 4'd1) begin
      miss_cnt++;
      $display("FAIL t6_pre_reset: got v=%0b evt=%0h down=%0d expected v=1 evt=%0h down=1",
               evt_valid, got_evt, keys_down, exp_evt);
    end
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd0) begin
      miss_cnt++;
      $display("FAIL t6_async_drop: got v=%0b down=%0d expected v=0 down=0", evt_valid, keys_down);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    exp_evt = '{key: 3'd0, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t6_repress_key0: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    evt_ready = 1'b1;
    tick();
    tick();
    exp_evt = '{key: 3'd3, press: 1'b1};
    vec_cnt++;
    if (evt_valid !== 1'b1 || got_evt !== exp_evt) begin
      miss_cnt++;
      $display("FAIL t6_repress_key3: got v=%0b evt=%0h expected v=1 evt=%0h", evt_valid, got_evt, exp_evt);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || keys_down !== 4'd2) begin
      miss_cnt++;
      $display("FAIL t6_final_down: got v=%0b down=%0d expected v=0 down=2", evt_valid, keys_down);
    end
  endtask

  initial begin
    rst       = 1'b0;
    key_level = 8'h00;
    evt_ready = 1'b0;
    test_reset();
    test_first_press();
    test_hold_offer();
    test_round_robin();
    test_coalesce();
    test_reversal();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
